// File: rtl/rs_gf16_pkg.sv
// Shared definitions for the GF(16) Reed-Solomon encoder.
// - Field polynomial x^4 + x + 1 (primitive element alpha = 2).
// - Generator coefficients g0..g3 of g(x) = x^4 + 13x^3 + 12x^2 + 8x + 7.
// - Encoder FSM state encoding.
// - gf16_mul: constant-free GF(16) multiply used by the multiplier cell.
package rs_gf16_pkg;

    localparam logic [4:0] GF_POLY = 5'b10011;
    localparam int         N       = 15;
    localparam int         K       = 11;

    // Index i holds the coefficient of x^i in g(x).
    localparam logic [3:0] G_COEF [0:3] = '{4'd7, 4'd8, 4'd12, 4'd13};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSG  = 2'd1,
        ST_PAR  = 2'd2
    } enc_state_e;

    // Shift-and-add multiply; the reduction folds x^4 back as x + 1.
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'd0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end else begin
                acc = acc;
            end
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? GF_POLY[3:0] : 4'd0);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf16mul_enc.sv
// Combinational GF(16) multiplier p = a * b.
// Ports:
// - a_i : 4-bit operand
// - b_i : 4-bit operand (tied to a generator coefficient by the encoder)
// - p_o : 4-bit product
module gf16mul_enc
    import rs_gf16_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] p_o
);

    assign p_o = gf16_mul(a_i, b_i);

endmodule

// File: rtl/rs_enc_gf16.sv
// Systematic RS(15,11) encoder over GF(16), t = 2; shortened via MSG_LEN.
// Message symbols are passed through with one cycle of latency, followed by
// four parity symbols (highest-degree first) taken from the division LFSR.
// Ports:
// - clk, rst_n           : clock, asynchronous active-low reset
// - din, din_sop         : message symbol and start-of-message flag
// - din_valid, din_ready : input handshake
// - dout, dout_sop       : codeword symbol and first-symbol flag
// - dout_eop, dout_par   : last-parity flag, parity-symbol flag
// - dout_valid, dout_ready : output handshake (single registered slot)
// - err_abort            : one-cycle pulse when a word is restarted early
module rs_enc_gf16
    import rs_gf16_pkg::*;
#(
    parameter int MSG_LEN = 11,
    parameter int PAR_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] din,
    input  logic       din_sop,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [3:0] dout,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic       dout_par,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       err_abort
);

    if (PAR_LEN != 4) begin : g_par_len_chk
        $error("rs_enc_gf16: PAR_LEN must be 4");
    end
    if ((MSG_LEN < 1) || (MSG_LEN > K)) begin : g_msg_len_chk
        $error("rs_enc_gf16: MSG_LEN must be 1..11");
    end

    localparam logic [3:0] LAST_MSG = 4'(MSG_LEN);

    enc_state_e state_q, state_d;
    logic [3:0] sym_cnt_q, sym_cnt_d;
    logic [1:0] par_cnt_q, par_cnt_d;
    logic [3:0] r_q [0:3];
    logic [3:0] r_d [0:3];
    logic [3:0] dout_q, dout_d;
    logic       dout_sop_q, dout_sop_d;
    logic       dout_eop_q, dout_eop_d;
    logic       dout_par_q, dout_par_d;
    logic       dout_valid_q, dout_valid_d;
    logic       err_abort_q, err_abort_d;

    logic       slot_free_s;
    logic       din_ready_s;
    logic       acc_s;
    logic [3:0] fb_s;
    logic [3:0] fbg_s [0:3];
    logic [3:0] r_upd_s [0:3];
    logic [3:0] cnt_nxt_s;

    assign slot_free_s = !dout_valid_q | dout_ready;
    assign din_ready_s = (state_q != ST_PAR) & slot_free_s;
    assign acc_s       = din_valid & din_ready_s;

    // A start-of-message symbol sees an all-zero remainder, which reseeds the LFSR.
    assign fb_s = din ^ (din_sop ? 4'd0 : r_q[3]);

    for (genvar gi = 0; gi < 4; gi++) begin : g_mul
        gf16mul_enc u_mul (
            .a_i (fb_s),
            .b_i (G_COEF[gi]),
            .p_o (fbg_s[gi])
        );
    end

    assign r_upd_s[3] = (din_sop ? 4'd0 : r_q[2]) ^ fbg_s[3];
    assign r_upd_s[2] = (din_sop ? 4'd0 : r_q[1]) ^ fbg_s[2];
    assign r_upd_s[1] = (din_sop ? 4'd0 : r_q[0]) ^ fbg_s[1];
    assign r_upd_s[0] = fbg_s[0];

    assign cnt_nxt_s = din_sop ? 4'd1 : (sym_cnt_q + 4'd1);

    // Next-state logic for FSM, counters, LFSR and the output slot.
    always_comb begin
        state_d      = state_q;
        sym_cnt_d    = sym_cnt_q;
        par_cnt_d    = par_cnt_q;
        r_d          = r_q;
        dout_d       = dout_q;
        dout_sop_d   = dout_sop_q;
        dout_eop_d   = dout_eop_q;
        dout_par_d   = dout_par_q;
        err_abort_d  = 1'b0;
        if (slot_free_s) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end

        case (state_q)
            ST_IDLE, ST_MSG: begin
                // In IDLE only a start-of-message symbol is used; others are dropped.
                if (acc_s && (din_sop || (state_q == ST_MSG))) begin
                    dout_d       = din;
                    dout_sop_d   = din_sop;
                    dout_eop_d   = 1'b0;
                    dout_par_d   = 1'b0;
                    dout_valid_d = 1'b1;
                    r_d          = r_upd_s;
                    sym_cnt_d    = cnt_nxt_s;
                    err_abort_d  = din_sop && (state_q == ST_MSG);
                    if (cnt_nxt_s == LAST_MSG) begin
                        state_d = ST_PAR;
                    end else begin
                        state_d = ST_MSG;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_PAR: begin
                if (slot_free_s) begin
                    dout_d       = r_q[3];
                    dout_sop_d   = 1'b0;
                    dout_par_d   = 1'b1;
                    dout_eop_d   = (par_cnt_q == 2'd3);
                    dout_valid_d = 1'b1;
                    r_d[3]       = r_q[2];
                    r_d[2]       = r_q[1];
                    r_d[1]       = r_q[0];
                    r_d[0]       = 4'd0;
                    if (par_cnt_q == 2'd3) begin
                        state_d   = ST_IDLE;
                        par_cnt_d = 2'd0;
                        sym_cnt_d = 4'd0;
                    end else begin
                        par_cnt_d = par_cnt_q + 2'd1;
                    end
                end else begin
                    state_d = ST_PAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, LFSR and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sym_cnt_q    <= 4'd0;
            par_cnt_q    <= 2'd0;
            r_q          <= '{default: 4'd0};
            dout_q       <= 4'd0;
            dout_sop_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
            dout_par_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            err_abort_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            par_cnt_q    <= par_cnt_d;
            r_q          <= r_d;
            dout_q       <= dout_d;
            dout_sop_q   <= dout_sop_d;
            dout_eop_q   <= dout_eop_d;
            dout_par_q   <= dout_par_d;
            dout_valid_q <= dout_valid_d;
            err_abort_q  <= err_abort_d;
        end
    end

    assign din_ready  = din_ready_s;
    assign dout       = dout_q;
    assign dout_sop   = dout_sop_q;
    assign dout_eop   = dout_eop_q;
    assign dout_par   = dout_par_q;
    assign dout_valid = dout_valid_q;
    assign err_abort  = err_abort_q;

endmodule

// File: tb/tb_rs_enc_gf16.sv
// Scoreboard bench for rs_enc_gf16: a full-length instance (A, MSG_LEN 11)
// and a shortened instance (B, MSG_LEN 5). Stimulus pushes expected symbols
// into per-instance queues; monitors pop and compare on every transfer and
// check codeword syndromes at end of word.
module tb_rs_enc_gf16;

    typedef struct packed {
        logic [3:0] sym;
        logic       sop;
        logic       par;
        logic       eop;
        logic       chk;
    } sb_entry_t;

    typedef logic [3:0] sym_arr_t [11];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0] a_din, b_din, a_dout, b_dout;
    logic a_din_sop, a_din_valid, a_din_ready, a_dout_sop, a_dout_eop, a_dout_par;
    logic a_dout_valid, a_dout_ready, a_err_abort;
    logic b_din_sop, b_din_valid, b_din_ready, b_dout_sop, b_dout_eop, b_dout_par;
    logic b_dout_valid, b_dout_ready, b_err_abort;

    rs_enc_gf16 #(.MSG_LEN(11), .PAR_LEN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .din(a_din), .din_sop(a_din_sop),
        .din_valid(a_din_valid), .din_ready(a_din_ready), .dout(a_dout),
        .dout_sop(a_dout_sop), .dout_eop(a_dout_eop), .dout_par(a_dout_par),
        .dout_valid(a_dout_valid), .dout_ready(a_dout_ready), .err_abort(a_err_abort)
    );

    rs_enc_gf16 #(.MSG_LEN(5), .PAR_LEN(4)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .din(b_din), .din_sop(b_din_sop),
        .din_valid(b_din_valid), .din_ready(b_din_ready), .dout(b_dout),
        .dout_sop(b_dout_sop), .dout_eop(b_dout_eop), .dout_par(b_dout_par),
        .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .err_abort(b_err_abort)
    );

    int n_checks = 0;
    int n_fail   = 0;
    sb_entry_t qa[$];
    sb_entry_t qb[$];
    int rdy_mode = 0;
    int abort_a_hi = 0;
    int abort_b_hi = 0;

    logic [3:0] gexp [15];
    int         glog [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] tmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'd0 || b == 4'd0) return 4'd0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    // Horner evaluation of the received word at alpha^1..alpha^4, S1 in the top nibble.
    function automatic logic [15:0] syndromes(input logic [3:0] w [15], input int len);
        logic [15:0] res;
        logic [3:0]  s;
        res = 16'd0;
        for (int j = 1; j <= 4; j++) begin
            s = 4'd0;
            for (int i = 0; i < len; i++) s = tmul(s, gexp[j]) ^ w[i];
            res = {res[11:0], s};
        end
        return res;
    endfunction

    initial begin
        logic [3:0] v;
        v = 4'd1;
        glog[0] = 0;
        for (int i = 0; i < 15; i++) begin
            gexp[i] = v;
            glog[v] = i;
            v = {v[2:0], 1'b0} ^ (v[3] ? 4'b0011 : 4'b0000);
        end
    end

    // Downstream ready generation.
    int stall_t = 0;
    initial begin
        a_dout_ready = 1'b1;
        b_dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) begin
                a_dout_ready = ($urandom_range(0, 3) != 0);
                b_dout_ready = ($urandom_range(0, 3) != 0);
                stall_t = 0;
            end else if (rdy_mode == 2) begin
                stall_t++;
                a_dout_ready = !((stall_t >= 4 && stall_t <= 6) || (stall_t >= 16 && stall_t <= 18));
                b_dout_ready = 1'b1;
            end else begin
                a_dout_ready = 1'b1;
                b_dout_ready = 1'b1;
                stall_t = 0;
            end
        end
    end

    // Monitor A: scoreboard compare and end-of-word syndrome check.
    logic [3:0] wa [15];
    int wa_len = 0;
    always @(negedge clk) begin
        sb_entry_t e;
        if (!rst_n) begin
            wa_len = 0;
        end else if (a_dout_valid && a_dout_ready) begin
            if (a_dout_sop) wa_len = 0;
            if (wa_len < 15) begin
                wa[wa_len] = a_dout;
                wa_len++;
            end
            if (qa.size() == 0) begin
                check("A unexpected output", 32'({a_dout, a_dout_sop, a_dout_par, a_dout_eop}), 32'hFFFF);
            end else begin
                e = qa.pop_front();
                check("A symbol", 32'({e.chk ? a_dout : 4'd0, a_dout_sop, a_dout_par, a_dout_eop}),
                      32'({e.chk ? e.sym : 4'd0, e.sop, e.par, e.eop}));
            end
            if (a_dout_eop) check("A syndromes", {wa_len[15:0], syndromes(wa, wa_len)}, {16'd15, 16'd0});
        end
        if (rst_n && a_err_abort) abort_a_hi++;
    end

    // Monitor B: same checks for the shortened code (9-symbol codewords).
    logic [3:0] wb [15];
    int wb_len = 0;
    always @(negedge clk) begin
        sb_entry_t e;
        if (!rst_n) begin
            wb_len = 0;
        end else if (b_dout_valid && b_dout_ready) begin
            if (b_dout_sop) wb_len = 0;
            if (wb_len < 15) begin
                wb[wb_len] = b_dout;
                wb_len++;
            end
            if (qb.size() == 0) begin
                check("B unexpected output", 32'({b_dout, b_dout_sop, b_dout_par, b_dout_eop}), 32'hFFFF);
            end else begin
                e = qb.pop_front();
                check("B symbol", 32'({e.chk ? b_dout : 4'd0, b_dout_sop, b_dout_par, b_dout_eop}),
                      32'({e.chk ? e.sym : 4'd0, e.sop, e.par, e.eop}));
            end
            if (b_dout_eop) check("B syndromes", {wb_len[15:0], syndromes(wb, wb_len)}, {16'd9, 16'd0});
        end
        if (rst_n && b_err_abort) abort_b_hi++;
    end

    // Backpressure watcher on A: stalled outputs hold, input side is closed.
    logic [8:0] prev_bus = 9'd0;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst_n && prev_stall)
            check("A hold under stall", 32'({a_dout, a_dout_sop, a_dout_eop, a_dout_par, a_dout_valid}), 32'(prev_bus));
        if (rst_n && a_dout_valid && !a_dout_ready)
            check("A din_ready under stall", 32'(a_din_ready), 32'd0);
        prev_bus   = {a_dout, a_dout_sop, a_dout_eop, a_dout_par, a_dout_valid};
        prev_stall = rst_n && a_dout_valid && !a_dout_ready;
    end

    task automatic push(input bit b, input logic [3:0] sym, input logic sop,
                        input logic par, input logic eop, input logic chk);
        sb_entry_t e;
        e = '{sym: sym, sop: sop, par: par, eop: eop, chk: chk};
        if (b) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    task automatic send_sym(input bit b, input logic [3:0] sym, input logic sop, input int gap);
        logic rdy;
        bit   ok;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        if (b) begin b_din = sym; b_din_sop = sop; b_din_valid = 1'b1; end
        else   begin a_din = sym; a_din_sop = sop; a_din_valid = 1'b1; end
        ok = 1'b0;
        for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge clk);
            rdy = b ? b_din_ready : a_din_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        if (!ok) check("input accept timeout", 32'd0, 32'd1);
        if (b) begin b_din_valid = 1'b0; b_din_sop = 1'b0; end
        else   begin a_din_valid = 1'b0; a_din_sop = 1'b0; end
    endtask

    task automatic send_word(input bit b, input sym_arr_t msg, input int len, input bit rnd_gap,
                             input bit par_known, input logic [15:0] par);
        logic [15:0] p;
        for (int i = 0; i < len; i++) begin
            push(b, msg[i], (i == 0), 1'b0, 1'b0, 1'b1);
            send_sym(b, msg[i], (i == 0), rnd_gap ? int'($urandom_range(0, 2)) : 0);
        end
        p = par;
        for (int i = 0; i < 4; i++) begin
            push(b, p[15:12], 1'b0, 1'b1, (i == 3), par_known);
            p = {p[11:0], 4'd0};
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && (qa.size() + qb.size()) != 0; t++) @(negedge clk);
        check("drain", 32'(qa.size() + qb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        sym_arr_t m;
        bit hit;
        int pcnt;
        rst_n = 1'b0;
        a_din = 4'd0; a_din_sop = 1'b0; a_din_valid = 1'b0;
        b_din = 4'd0; b_din_sop = 1'b0; b_din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("A reset outputs", 32'({a_dout, a_dout_sop, a_dout_eop, a_dout_par, a_dout_valid, a_err_abort}), 32'd0);
        check("B reset outputs", 32'({b_dout, b_dout_sop, b_dout_eop, b_dout_par, b_dout_valid, b_err_abort}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Symbol without sop while idle is dropped (nothing pushed).
        send_sym(1'b0, 4'd9, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;

        // T1: all-zero message.
        m = '{default: 4'd0};
        send_word(1'b0, m, 11, 1'b0, 1'b1, 16'h0000);
        // T2: single 1 in the last position yields the generator coefficients.
        m[10] = 4'd1;
        send_word(1'b0, m, 11, 1'b0, 1'b1, 16'hDC87);
        drain();

        // T4: stalls mid-message and during parity.
        for (int i = 0; i < 11; i++) m[i] = 4'(i + 1);
        rdy_mode = 2;
        send_word(1'b0, m, 11, 1'b0, 1'b0, 16'h0000);
        drain();
        rdy_mode = 0;

        // T3: random messages with random gaps and backpressure.
        rdy_mode = 1;
        for (int w = 0; w < 200; w++) begin
            for (int i = 0; i < 11; i++) m[i] = 4'($urandom_range(0, 15));
            send_word(1'b0, m, 11, 1'b1, 1'b0, 16'h0000);
        end
        for (int w = 0; w < 20; w++) begin
            for (int i = 0; i < 11; i++) m[i] = 4'($urandom_range(0, 15));
            send_word(1'b1, m, 5, 1'b1, 1'b0, 16'h0000);
        end
        drain();
        rdy_mode = 0;

        // T5: sop on the 6th symbol restarts the word.
        check("A abort before restart", 32'(abort_a_hi), 32'd0);
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 4'(i + 3), (i == 0), 1'b0, 1'b0, 1'b1);
            send_sym(1'b0, 4'(i + 3), (i == 0), 0);
        end
        m = '{default: 4'd0};
        m[10] = 4'd1;
        send_word(1'b0, m, 11, 1'b0, 1'b1, 16'hDC87);
        drain();
        check("A abort single pulse", 32'(abort_a_hi), 32'd1);

        // T6: reset during the second parity symbol.
        send_word(1'b0, m, 11, 1'b0, 1'b1, 16'hDC87);
        hit = 1'b0;
        pcnt = 0;
        for (int t = 0; t < 100 && !hit; t++) begin
            @(negedge clk);
            if (a_dout_valid && a_dout_par) pcnt++;
            if (pcnt == 2) hit = 1'b1;
        end
        check("A reached 2nd parity", 32'(hit), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("A async reset outputs", 32'({a_dout, a_dout_sop, a_dout_eop, a_dout_par, a_dout_valid, a_err_abort}), 32'd0);
        check("A leftover parity", 32'(qa.size()), 32'd2);
        qa.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m = '{default: 4'd0};
        m[4] = 4'd1;
        send_word(1'b1, m, 5, 1'b0, 1'b1, 16'hDC87);
        m[4] = 4'd0;
        m[10] = 4'd1;
        send_word(1'b0, m, 11, 1'b0, 1'b1, 16'hDC87);
        drain();
        check("B never aborts", 32'(abort_b_hi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
